opcode_fetch: RTL and testbench

Front-end sequencer of the 6809 core, directly upstream of the extended, direct and indexed addressing sequencers. It fetches the opcode byte at PC and handles 0x10/0x11 page prefixes. It classifies the addressing mode, pulses the matching addressing sequencer's start and waits for that sequencer's active to fall. It then presents the decoded instruction to the execute stage with a valid/ready handshake.

---
 rtl/d6809_pkg.sv | 56 +++++
 rtl/opcode_fetch.sv | 139 +++++++++++++
 tb/tb_opcode_fetch.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/d6809_pkg.sv
// rtl/d6809_pkg.sv - shared 6809 front-end encodings and opcode mode decode
//
// Purpose: mode/page encodings, page prefix bytes, front-end FSM states and
//          the addressing-mode classifier shared with the execute stage.
// Ports:   none (package).
package d6809_pkg;

    localparam logic [7:0] PREFIX_P2 = 8'h10;
    localparam logic [7:0] PREFIX_P3 = 8'h11;

    typedef enum logic [2:0] {
        MODE_INH = 3'd0,
        MODE_IMM = 3'd1,
        MODE_DIR = 3'd2,
        MODE_IDX = 3'd3,
        MODE_EXT = 3'd4
    } mode_e;

    typedef enum logic [1:0] {
        PAGE_1 = 2'd0,
        PAGE_2 = 2'd2,
        PAGE_3 = 2'd3
    } page_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH_OP  = 3'd1,
        ST_FETCH_OP2 = 3'd2,
        ST_DECODE    = 3'd3,
        ST_START_EA  = 3'd4,
        ST_WAIT_EA   = 3'd5,
        ST_ISSUE     = 3'd6
    } fetch_state_e;

    // Classification depends only on the high nibble; the page prefix never
    // changes the addressing mode.
    function automatic mode_e mode_decode(input logic [7:0] op);
        mode_e m;
        case (op[7:4])
            4'h0:                         m = MODE_DIR;
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5: m = MODE_INH;
            4'h6:                         m = MODE_IDX;
            4'h7:                         m = MODE_EXT;
            default: begin
                case (op[5:4])
                    2'b00:   m = MODE_IMM;
                    2'b01:   m = MODE_DIR;
                    2'b10:   m = MODE_IDX;
                    default: m = MODE_EXT;
                endcase
            end
        endcase
        return m;
    endfunction

endpackage

// File: rtl/opcode_fetch.sv
// rtl/opcode_fetch.sv - 6809 opcode fetch, prefix handling and EA sequencing
//
// Purpose: fetches the opcode (with 0x10/0x11 page prefixes), classifies its
//          addressing mode, kicks the matching EA sequencer and hands the
//          decoded instruction to execute with a valid/ready handshake.
// Ports:
//   clk, reset                     core clock, synchronous active-high reset
//   fetch_en                       allow a new fetch from IDLE
//   data_in                        memory byte at PC (same cycle as mem_read_pc)
//   mem_read_pc, pc_inc            memory read / PC increment strobes
//   ext/dir/idx_start, *_active    EA sequencer start pulses and busy flags
//   opcode, page, mode             latched decoded instruction
//   op_valid, op_ready             handshake to execute stage
module opcode_fetch
    import d6809_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       fetch_en,
    input  logic [7:0] data_in,
    output logic       mem_read_pc,
    output logic       pc_inc,
    output logic       ext_start,
    input  logic       ext_active,
    output logic       dir_start,
    input  logic       dir_active,
    output logic       idx_start,
    input  logic       idx_active,
    output logic [7:0] opcode,
    output logic [1:0] page,
    output logic [2:0] mode,
    output logic       op_valid,
    input  logic       op_ready
);

    fetch_state_e state_q, state_d;
    logic [7:0]   opcode_q, opcode_d;
    page_e        page_q, page_d;
    mode_e        mode_q, mode_d;
    logic         sel_active;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            opcode_q <= 8'h00;
            page_q   <= PAGE_1;
            mode_q   <= MODE_INH;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            page_q   <= page_d;
            mode_q   <= mode_d;
        end
    end

    // Only the sequencer we started matters; the others may be busy with
    // unrelated work and are ignored.
    always_comb begin
        sel_active = 1'b0;
        case (mode_q)
            MODE_DIR: sel_active = dir_active;
            MODE_IDX: sel_active = idx_active;
            MODE_EXT: sel_active = ext_active;
            default:  sel_active = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        page_d   = page_q;
        mode_d   = mode_q;
        case (state_q)
            ST_IDLE: begin
                if (fetch_en) begin
                    page_d  = PAGE_1;
                    state_d = ST_FETCH_OP;
                end
            end
            ST_FETCH_OP, ST_FETCH_OP2: begin
                // Repeated prefixes keep us here; the last one seen wins.
                if (data_in == PREFIX_P2) begin
                    page_d  = PAGE_2;
                    state_d = ST_FETCH_OP2;
                end else if (data_in == PREFIX_P3) begin
                    page_d  = PAGE_3;
                    state_d = ST_FETCH_OP2;
                end else begin
                    opcode_d = data_in;
                    state_d  = ST_DECODE;
                end
            end
            ST_DECODE: begin
                mode_d = mode_decode(opcode_q);
                if (mode_d == MODE_DIR || mode_d == MODE_IDX || mode_d == MODE_EXT)
                    state_d = ST_START_EA;
                else
                    state_d = ST_ISSUE;
            end
            ST_START_EA: state_d = ST_WAIT_EA;
            ST_WAIT_EA: begin
                if (!sel_active)
                    state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (op_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_read_pc = 1'b0;
        pc_inc      = 1'b0;
        ext_start   = 1'b0;
        dir_start   = 1'b0;
        idx_start   = 1'b0;
        op_valid    = 1'b0;
        case (state_q)
            ST_FETCH_OP, ST_FETCH_OP2: begin
                mem_read_pc = 1'b1;
                pc_inc      = 1'b1;
            end
            ST_START_EA: begin
                dir_start = (mode_q == MODE_DIR);
                idx_start = (mode_q == MODE_IDX);
                ext_start = (mode_q == MODE_EXT);
            end
            ST_ISSUE: op_valid = 1'b1;
            default: ;
        endcase
    end

    assign opcode = opcode_q;
    assign page   = page_q;
    assign mode   = mode_q;

endmodule

// File: tb/tb_opcode_fetch.sv
// tb/tb_opcode_fetch.sv - directed self-checking bench for opcode_fetch
module tb_opcode_fetch;

    logic       clk = 1'b0;
    logic       reset;
    logic       fetch_en;
    logic [7:0] data_in;
    logic       mem_read_pc;
    logic       pc_inc;
    logic       ext_start;
    logic       ext_active;
    logic       dir_start;
    logic       dir_active;
    logic       idx_start;
    logic       idx_active;
    logic [7:0] opcode;
    logic [1:0] page;
    logic [2:0] mode;
    logic       op_valid;
    logic       op_ready;

    opcode_fetch dut (
        .clk(clk), .reset(reset), .fetch_en(fetch_en), .data_in(data_in),
        .mem_read_pc(mem_read_pc), .pc_inc(pc_inc),
        .ext_start(ext_start), .ext_active(ext_active),
        .dir_start(dir_start), .dir_active(dir_active),
        .idx_start(idx_start), .idx_active(idx_active),
        .opcode(opcode), .page(page), .mode(mode),
        .op_valid(op_valid), .op_ready(op_ready)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem [4];
    int nbytes, ptr, cyc, start_cyc;
    int n_rd, n_inc, n_ext, n_dir, n_idx;
    int ext_len = 2, dir_len = 1, idx_len = 3;
    int ext_cnt = 0, dir_cnt = 0, idx_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: tally strobes before the edge, then update the sequencer
    // models and the memory byte after it.
    task automatic tick();
        logic s_ext, s_dir, s_idx, inc;
        s_ext = ext_start; s_dir = dir_start; s_idx = idx_start; inc = pc_inc;
        if (mem_read_pc) n_rd++;
        if (pc_inc) n_inc++;
        if (ext_start) n_ext++;
        if (dir_start) n_dir++;
        if (idx_start) n_idx++;
        if ((ext_start || dir_start || idx_start) && start_cyc < 0) start_cyc = cyc;
        @(posedge clk); #1;
        cyc++;
        if (s_ext) ext_cnt = ext_len; else if (ext_cnt > 0) ext_cnt--;
        if (s_dir) dir_cnt = dir_len; else if (dir_cnt > 0) dir_cnt--;
        if (s_idx) idx_cnt = idx_len; else if (idx_cnt > 0) idx_cnt--;
        ext_active = (ext_cnt > 0);
        dir_active = (dir_cnt > 0);
        idx_active = (idx_cnt > 0);
        if (inc) ptr++;
        data_in = (ptr < nbytes) ? mem[ptr] : 8'h00;
    endtask

    task automatic clear_counts();
        cyc = 0; start_cyc = -1;
        n_rd = 0; n_inc = 0; n_ext = 0; n_dir = 0; n_idx = 0;
    endtask

    task automatic load(input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2, input int nb);
        mem[0] = b0; mem[1] = b1; mem[2] = b2; mem[3] = 8'h00;
        nbytes = nb; ptr = 0; data_in = mem[0];
    endtask

    task automatic run_instr(input string tag,
                             input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input int nb,
                             input logic [7:0] e_op, input logic [1:0] e_pg,
                             input logic [2:0] e_md, input int e_lat,
                             input int e_ext, input int e_dir, input int e_idx,
                             input int e_start_cyc, input int hold);
        clear_counts();
        load(b0, b1, b2, nb);
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        while (!op_valid && cyc < 60) tick();
        check({tag, ".latency"}, cyc, e_lat);
        check({tag, ".opcode"}, opcode, e_op);
        check({tag, ".page"}, page, e_pg);
        check({tag, ".mode"}, mode, e_md);
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, ".hold_valid"}, op_valid, 1'b1);
            check({tag, ".hold_opcode"}, opcode, e_op);
            check({tag, ".hold_mode"}, mode, e_md);
        end
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;
        check({tag, ".accepted"}, op_valid, 1'b0);
        tick();
        check({tag, ".pc_inc_cnt"}, n_inc, nb);
        check({tag, ".rd_cnt"}, n_rd, nb);
        check({tag, ".ext_cnt"}, n_ext, e_ext);
        check({tag, ".dir_cnt"}, n_dir, e_dir);
        check({tag, ".idx_cnt"}, n_idx, e_idx);
        if (e_start_cyc >= 0) check({tag, ".start_cyc"}, start_cyc, e_start_cyc);
    endtask

    initial begin
        reset = 1'b1; fetch_en = 1'b0; op_ready = 1'b0; data_in = 8'h00;
        ext_active = 1'b0; dir_active = 1'b0; idx_active = 1'b0;
        clear_counts();
        load(8'h00, 8'h00, 8'h00, 0);
        repeat (2) tick();
        check("rst.strobes", {mem_read_pc, pc_inc, ext_start, dir_start, idx_start, op_valid}, 6'b0);
        check("rst.outs", {opcode, page, mode}, 13'b0);
        reset = 1'b0;

        // fetch_en low in IDLE: no memory activity
        clear_counts();
        repeat (5) tick();
        check("idle.rd_cnt", n_rd, 0);

        // tag, bytes, nb, opcode, page, mode, latency, ext/dir/idx, start cycle, hold
        run_instr("ext_b6",  8'hB6, 8'h00, 8'h00, 1, 8'hB6, 2'd0, 3'd4, 7, 1, 0, 0, 3, 0);
        run_instr("idx_10ae", 8'h10, 8'hAE, 8'h00, 2, 8'hAE, 2'd2, 3'd3, 9, 0, 0, 1, 4, 0);
        run_instr("imm_dbl", 8'h10, 8'h11, 8'h86, 3, 8'h86, 2'd3, 3'd1, 5, 0, 0, 0, -1, 0);
        run_instr("inh_bp",  8'h12, 8'h00, 8'h00, 1, 8'h12, 2'd0, 3'd0, 3, 0, 0, 0, -1, 5);
        run_instr("dir_0c",  8'h0C, 8'h00, 8'h00, 1, 8'h0C, 2'd0, 3'd2, 6, 0, 1, 0, 3, 0);
        run_instr("dir_96",  8'h96, 8'h00, 8'h00, 1, 8'h96, 2'd0, 3'd2, 6, 0, 1, 0, 3, 0);
        run_instr("p3_ext",  8'h11, 8'hBE, 8'h00, 2, 8'hBE, 2'd3, 3'd4, 8, 1, 0, 0, 4, 0);

        // Reset while waiting on a long extended sequencer
        ext_len = 20;
        clear_counts();
        load(8'hB6, 8'h00, 8'h00, 1);
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        while (!ext_active && cyc < 20) tick();
        check("rwait.reached", ext_active, 1'b1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rwait.strobes", {mem_read_pc, pc_inc, ext_start, dir_start, idx_start, op_valid}, 6'b0);
        check("rwait.outs", {opcode, page, mode}, 13'b0);
        check("rwait.ext_still_busy", ext_active, 1'b1);
        clear_counts();
        repeat (4) tick();
        check("rwait.no_issue", op_valid, 1'b0);
        check("rwait.no_rd", n_rd, 0);
        check("rwait.no_start", n_ext + n_dir + n_idx, 0);
        ext_cnt = 0; ext_len = 2;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
